vx_cache_data_wb: RTL

- Write-back cache data store for one bank, NUM_WAYS-way set-associative.
- Keeps per-way line data plus per-byte dirty masks.
- Serves word reads, byte-masked writes and line fills.
- Emits dirty victims on a valid/ready eviction port; an internal flush walker drains every dirty line on command.
- Sits between the bank tag/lookup pipeline and the memory-request arbiter.

---
 rtl/vx_cache_data_wb.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/vx_cache_data_wb.sv
// rtl/vx_cache_data_wb.sv - write-back cache data store for one bank
// Holds line data and per-byte dirty masks; spills dirty victims on fills and on a flush walk.
module vx_cache_data_wb #(
    parameter int LINES       = 64,
    parameter int NUM_WAYS    = 2,
    parameter int LINE_SIZE   = 16,
    parameter int WORD_SIZE   = 4,
    parameter int DIRTY_BYTES = 1,
    localparam int LW  = $clog2(LINES),
    localparam int WW  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
    localparam int WDW = ((LINE_SIZE / WORD_SIZE) > 1) ? $clog2(LINE_SIZE / WORD_SIZE) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [1:0]             req_op,
    input  logic [LW-1:0]          req_line,
    input  logic [WW-1:0]          req_way,
    input  logic [WDW-1:0]         req_word,
    input  logic [WORD_SIZE-1:0]   req_byteen,
    input  logic [8*WORD_SIZE-1:0] req_wdata,
    input  logic [8*LINE_SIZE-1:0] req_fill_data,
    output logic                   rsp_valid,
    output logic [8*WORD_SIZE-1:0] rsp_data,
    input  logic                   flush_start,
    output logic                   flush_busy,
    output logic                   flush_done,
    output logic                   evict_valid,
    input  logic                   evict_ready,
    output logic [LW-1:0]          evict_line,
    output logic [WW-1:0]          evict_way,
    output logic [8*LINE_SIZE-1:0] evict_data,
    output logic [LINE_SIZE-1:0]   evict_byteen
);
    localparam int WORDS   = LINE_SIZE / WORD_SIZE;
    localparam int ENTRIES = LINES * NUM_WAYS;
    localparam int EW      = $clog2(ENTRIES);
    localparam int WBITS   = 8 * WORD_SIZE;

    typedef enum logic [1:0] {IDLE, SCAN, WAIT, DONE} state_t;

    logic [8*LINE_SIZE-1:0] data_q  [ENTRIES];
    logic [LINE_SIZE-1:0]   dirty_q [ENTRIES];

    state_t              state_q, state_d;
    logic [EW-1:0]       cur_q, cur_d;
    logic                flush_done_q, flush_done_d;
    logic                rsp_valid_q;
    logic [WBITS-1:0]    rsp_data_q;
    logic                evict_valid_q;
    logic [LW-1:0]       evict_line_q;
    logic [WW-1:0]       evict_way_q;
    logic [8*LINE_SIZE-1:0] evict_data_q;
    logic [LINE_SIZE-1:0]   evict_byteen_q;

    // Unused way/word bits fold away through the modulo on a power-of-two size.
    int            word_idx;
    logic [EW-1:0] req_idx;
    logic [WW-1:0] req_way_eff;
    assign word_idx    = int'(req_word) % WORDS;
    assign req_way_eff = WW'(int'(req_way) % NUM_WAYS);
    assign req_idx     = EW'(int'(req_line) * NUM_WAYS + int'(req_way_eff));

    logic buf_free, acc, do_read, do_write, do_fill, fill_evict, scan_evict;
    logic cur_dirty, cur_last;
    logic [LINE_SIZE-1:0] set_mask;

    assign buf_free   = !evict_valid_q || evict_ready;
    assign req_ready  = (state_q == IDLE) && buf_free;
    assign acc        = req_valid && req_ready;
    assign do_read    = acc && (req_op == 2'd0);
    assign do_write   = acc && (req_op == 2'd1);
    assign do_fill    = acc && (req_op == 2'd2);
    assign fill_evict = do_fill && (|dirty_q[req_idx]);
    assign cur_dirty  = |dirty_q[cur_q];
    assign cur_last   = (cur_q == EW'(ENTRIES - 1));

    always_comb begin
        set_mask = '0;
        for (int b = 0; b < WORD_SIZE; b++) begin
            set_mask[word_idx*WORD_SIZE + b] = req_byteen[b];
        end
        if (DIRTY_BYTES == 0) begin
            set_mask = (|req_byteen) ? '1 : '0;
        end
    end

    always_comb begin
        state_d      = state_q;
        cur_d        = cur_q;
        flush_done_d = 1'b0;
        scan_evict   = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush_start) begin
                    state_d = SCAN;
                    cur_d   = '0;
                end
            end
            SCAN: begin
                if (cur_dirty && !buf_free) begin
                    state_d = WAIT;
                end else begin
                    scan_evict = cur_dirty;
                    if (cur_last) state_d = DONE;
                    else          cur_d   = cur_q + 1'b1;
                end
            end
            WAIT: begin
                if (buf_free) state_d = SCAN;
            end
            DONE: begin
                if (!evict_valid_q) begin
                    state_d      = IDLE;
                    flush_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            cur_q          <= '0;
            flush_done_q   <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_data_q     <= '0;
            evict_valid_q  <= 1'b0;
            evict_line_q   <= '0;
            evict_way_q    <= '0;
            evict_data_q   <= '0;
            evict_byteen_q <= '0;
            for (int i = 0; i < ENTRIES; i++) dirty_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            flush_done_q <= flush_done_d;
            rsp_valid_q  <= do_read;
            if (do_read) rsp_data_q <= data_q[req_idx][word_idx*WBITS +: WBITS];

            // Fill victims and scan victims never coincide: requests stall while the walker runs.
            if (fill_evict) begin
                evict_valid_q  <= 1'b1;
                evict_line_q   <= req_line;
                evict_way_q    <= req_way_eff;
                evict_data_q   <= data_q[req_idx];
                evict_byteen_q <= dirty_q[req_idx];
            end else if (scan_evict) begin
                evict_valid_q  <= 1'b1;
                evict_line_q   <= LW'(int'(cur_q) / NUM_WAYS);
                evict_way_q    <= WW'(int'(cur_q) % NUM_WAYS);
                evict_data_q   <= data_q[cur_q];
                evict_byteen_q <= dirty_q[cur_q];
            end else if (evict_ready) begin
                evict_valid_q  <= 1'b0;
            end

            if (do_fill)         dirty_q[req_idx] <= '0;
            else if (do_write)   dirty_q[req_idx] <= dirty_q[req_idx] | set_mask;
            else if (scan_evict) dirty_q[cur_q]   <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (do_fill) begin
            data_q[req_idx] <= req_fill_data;
        end else if (do_write) begin
            for (int b = 0; b < WORD_SIZE; b++) begin
                if (req_byteen[b]) data_q[req_idx][(word_idx*WORD_SIZE + b)*8 +: 8] <= req_wdata[b*8 +: 8];
            end
        end
    end

    assign flush_busy   = (state_q != IDLE);
    assign flush_done   = flush_done_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign evict_valid  = evict_valid_q;
    assign evict_line   = evict_line_q;
    assign evict_way    = evict_way_q;
    assign evict_data   = evict_data_q;
    assign evict_byteen = evict_byteen_q;
endmodule
